piso_shift_tx: RTL and testbench
================================

# piso_shift_tx

Parallel-in, serial-out shift transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clock, with a qualifying valid strobe. It drives the serial input of the left-shift (serial-in, parallel-out) register. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 4: data word width in bits (≥ 2).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (rst = 0 resets on the next rising clk edge).
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data, MSB first; feeds the shift register's serial input.
- sout_valid  output  1  sout carries a valid bit this cycle.
- done  output  1  high during the last bit cycle of a word (last data bit, or parity bit when enabled).

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with PISO_PARITY_EN).
- Internal: shift register sreg[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH+1), parity accumulator.
- Accept: load_valid && load_ready at a clk edge loads sreg <= din, cnt <= WIDTH-1, state <= SHIFT.
- SHIFT: sout = sreg[WIDTH-1]; sout_valid = 1; each edge sreg <= {sreg[WIDTH-2:0],1'b0}, cnt decrements.
- Last data bit is cnt == 0; without parity, done = 1 on this cycle and state goes to IDLE, or back to SHIFT if a new word is accepted on the same edge.
- With parity: after cnt == 0 go to PARITY; sout = even-parity bit (XOR of the word); done = 1 there.
- load_ready = rst && (state == IDLE || the current cycle is the done cycle); combinational from registered state.
- load_valid while busy and not in the done cycle: ignored; din not sampled, no state change.
- IDLE: sout = 0, sout_valid = 0, done = 0.

## Timing
- Reset values (edge with rst = 0): state IDLE, sreg 0, cnt 0, sout 0, sout_valid 0, done 0; load_ready = 0 while rst is low, 1 in the first cycle after rst returns high.
- Latency: word accepted at edge N; MSB on sout during cycle N+1; bit i (MSB = 0) in cycle N+1+i; done in cycle N+WIDTH (N+WIDTH+1 with parity).
- Throughput: one word per WIDTH cycles (WIDTH+1 with parity); sout_valid stays high continuously across back-to-back words.
- Reset mid-word: aborts; remaining bits are discarded and never emitted; outputs take reset values from the next cycle.
- Simultaneous load and done: the new MSB appears in the cycle directly after done, with no gap.
- load_valid asserted while rst = 0: not accepted.
- All outputs change only on rising clk; no combinational path from din to sout.

## Configuration
- PISO_PARITY_EN defined: one extra PARITY cycle per word carries the even-parity bit (XOR of all WIDTH data bits) with sout_valid = 1 and done = 1; load_ready is asserted in the PARITY cycle, not in the last data cycle.
- Undefined: no PARITY state; a frame is exactly WIDTH bits; done is on the last data bit.

## Test plan
- Reset then single word: rst low 2 cycles, load 4'b1011 -> sout 1,0,1,1 in cycles N+1..N+4, sout_valid high 4 cycles, done only in cycle N+4, load_ready 0 in cycles N+1..N+3.
- Back-to-back: hold load_valid with 4'b1011, then 4'b0110 on the done cycle -> 8 contiguous valid bits 1,0,1,1,0,1,1,0 with no gap.
- Load while busy: pulse load_valid with 4'b1111 in cycle N+2 of word 4'b1000 -> output stays 1,0,0,0; 4'b1111 is never emitted.
- Reset mid-word: rst = 0 at the edge ending cycle N+2 of 4'b1011 -> sout and sout_valid are 0 from cycle N+3; the remaining bits are never emitted.
- Parity (PISO_PARITY_EN): 4'b1011 -> sout 1,0,1,1,1 with done in the 5th cycle; 4'b1001 -> parity bit 0.
- Loopback: sout/sout_valid drive the left-shift register enable and serial input -> after 4 bits of 4'b1011 its q reads 4'b1011.

Source files
------------

// File: rtl/piso_shift_tx_if.sv
// Handshake and serial-output bundle for piso_shift_tx.
// The master side produces words; the slave side (the transmitter) shifts them out.
interface piso_shift_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output din,
        output load_valid,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  done
    );

    modport slave (
        input  din,
        input  load_valid,
        output load_ready,
        output sout,
        output sout_valid,
        output done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, MSB first, back-to-back words without gaps.
// Define PISO_PARITY_EN to append an even-parity bit after every word.
//
// state  | meaning
// IDLE   | no word in flight, ready for a load
// SHIFT  | data bits on sout, cnt counts down to the last bit
// PARITY | even-parity bit on sout (only with PISO_PARITY_EN)
module piso_shift_tx #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    piso_shift_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             last_bit;
    logic             done_cyc;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par, par_nxt;
`endif

    assign last_bit = (state == SHIFT) && (cnt == '0);
`ifdef PISO_PARITY_EN
    assign done_cyc = (state == PARITY);
`else
    assign done_cyc = last_bit;
`endif

    // Ready in the done cycle lets the next word follow with no idle gap.
    assign bus.load_ready = rst && ((state == IDLE) || done_cyc);
    assign accept         = bus.load_valid && bus.load_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
`ifdef PISO_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
`ifdef PISO_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            SHIFT: begin
                sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                if (cnt == '0) begin
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
`endif
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: state_nxt = IDLE;
`endif
            default: ;
        endcase
        if (accept) begin
            sreg_nxt  = bus.din;
            cnt_nxt   = CW'(WIDTH - 1);
            state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
            par_nxt   = ^bus.din;
`endif
        end
    end

    always_comb begin
        bus.sout       = 1'b0;
        bus.sout_valid = 1'b0;
        bus.done       = 1'b0;
        case (state)
            SHIFT: begin
                bus.sout       = sreg[WIDTH-1];
                bus.sout_valid = 1'b1;
`ifndef PISO_PARITY_EN
                bus.done       = last_bit;
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                bus.sout       = par;
                bus.sout_valid = 1'b1;
                bus.done       = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: directed scenarios then random traffic, checked against
// a frame-queue model of the serial stream; also loops sout into a left-shift register.
module tb_piso_shift_tx;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    piso_shift_tx_if #(.WIDTH(WIDTH)) bus_if ();

    piso_shift_tx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receiving left-shift register fed by the serial output.
    logic [WIDTH-1:0] lb_q;
    always @(posedge clk) begin
        if (bus_if.sout_valid)
            lb_q <= {lb_q[WIDTH-2:0], bus_if.sout};
    end

    // Model: bits still to be emitted, head is the bit on sout this cycle.
    logic model_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic lv, input logic [WIDTH-1:0] d);
        logic exp_ready;
        logic exp_valid;
        logic exp_sout;
        logic exp_done;
        rst               = r;
        bus_if.load_valid = lv;
        bus_if.din        = d;
        @(negedge clk);
        exp_valid = (model_q.size() > 0);
        exp_sout  = exp_valid ? model_q[0] : 1'b0;
        exp_done  = (model_q.size() == 1);
        exp_ready = r && (model_q.size() <= 1);
        check("sout",       bus_if.sout,       exp_sout);
        check("sout_valid", bus_if.sout_valid, exp_valid);
        check("done",       bus_if.done,       exp_done);
        check("load_ready", bus_if.load_ready, exp_ready);
        if (!r) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0)
                void'(model_q.pop_front());
            if (lv && exp_ready) begin
                for (int i = WIDTH - 1; i >= 0; i--)
                    model_q.push_back(d[i]);
`ifdef PISO_PARITY_EN
                model_q.push_back(^d);
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b0;
        bus_if.load_valid = 1'b0;
        bus_if.din        = '0;
        lb_q              = '0;
        @(posedge clk);
        #1;

        // reset held, load attempt ignored while in reset
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'hF);

        // single word plus loopback
        step(1'b1, 1'b1, 4'b1011);
        for (int i = 0; i < WIDTH; i++) step(1'b1, 1'b0, 4'h0);
`ifdef PISO_PARITY_EN
        step(1'b1, 1'b0, 4'h0);
`endif
        step(1'b1, 1'b0, 4'h0);
`ifdef PISO_PARITY_EN
        check("loopback", lb_q, 4'b0111);
`else
        check("loopback", lb_q, 4'b1011);
`endif

        // back-to-back, second word presented on the done cycle
        step(1'b1, 1'b1, 4'b1011);
        for (int i = 0; i < WIDTH - 1; i++) step(1'b1, 1'b1, 4'b1011);
`ifdef PISO_PARITY_EN
        step(1'b1, 1'b1, 4'b1011);
`endif
        step(1'b1, 1'b1, 4'b0110);
        for (int i = 0; i < WIDTH + 2; i++) step(1'b1, 1'b0, 4'h0);

        // load while busy is ignored
        step(1'b1, 1'b1, 4'b1000);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < WIDTH + 2; i++) step(1'b1, 1'b0, 4'h0);

        // reset mid-word
        step(1'b1, 1'b1, 4'b1011);
        step(1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        for (int i = 0; i < WIDTH; i++) step(1'b1, 1'b0, 4'h0);

        // parity corner: even-weight word
        step(1'b1, 1'b1, 4'b1001);
        for (int i = 0; i < WIDTH + 2; i++) step(1'b1, 1'b0, 4'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) != 0),
                 1'($urandom_range(0, 1)),
                 WIDTH'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
